lcd_16x2_text_driver: RTL and testbench
=======================================

Name: lcd_16x2_text_driver

Overview:
- Sequential consumer of the 16x2 character ROMs: scans `char_xy` over 32 positions, samples `char_code`, and writes each byte to an HD44780-compatible 16x2 LCD.
- 8-bit parallel mode, write-only (`lcd_rw` tied low).
- Sits between the menu/difficulty ROMs and the board LCD pins.
- Performs power-up init once, then redraws the full screen on request.

Parameters:
- POWERUP_CYC, 2_000_000, cycles to wait after reset before the first command (20 ms at 100 MHz).
- E_PULSE_CYC, 50, cycles `lcd_e` is held high per byte.
- SETUP_CYC, 10, cycles `lcd_rs`/`lcd_data` are stable before `lcd_e` rises.
- CMD_WAIT_CYC, 5_000, cycles after `lcd_e` falls before the next byte (normal commands and data).
- CLEAR_WAIT_CYC, 200_000, cycles after `lcd_e` falls for the clear command (0x01).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- refresh  in  1  single-cycle pulse requesting a full-screen redraw
- char_xy  out  8  ROM address: bit 4 = row, bits 3:0 = column, bits 7:5 = 0
- char_code  in  7  ROM data for the current `char_xy`; combinational source
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  constant 0
- lcd_e  out  1  enable strobe
- lcd_data  out  8  LCD data bus
- busy  out  1  high from reset until DONE is left for IDLE, and during any redraw
- frame_done  out  1  one-cycle pulse after the 32nd character write completes

Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.

Behaviour:
- Reset values:
  - `lcd_e` = 0, `lcd_rs` = 0, `lcd_rw` = 0, `lcd_data` = 0x00, `char_xy` = 0x00.
  - `busy` = 1, `frame_done` = 0.
  - State = PWR_WAIT; timer cleared; pending-refresh flag cleared.
  - Reset mid-transfer forces all of the above immediately, including dropping `lcd_e`; the init sequence restarts from PWR_WAIT.
- Byte-write micro-sequence (shared sub-FSM):
  - SETUP: drive `lcd_rs`/`lcd_data`, hold SETUP_CYC cycles.
  - PULSE: `lcd_e` = 1 for E_PULSE_CYC cycles.
  - HOLD: `lcd_e` = 0; keep `lcd_data` for CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC if the byte was command 0x01.
  - `lcd_data`/`lcd_rs` change only in SETUP.
- Top FSM:
  - PWR_WAIT: count POWERUP_CYC, then go to INIT.
  - INIT: send commands 0x38, 0x0C, 0x01, 0x06 in order, then an implicit refresh into ADDR0 (first frame drawn without a request).
  - IDLE: `busy` = 0. A `refresh` pulse goes to ADDR0.
  - ADDR0: command 0x80.
  - ROW0: 16 data writes, `char_xy` = 0x00..0x0F.
  - ADDR1: command 0xC0.
  - ROW1: 16 data writes, `char_xy` = 0x10..0x1F.
  - DONE: pulse `frame_done` for 1 cycle, then go to IDLE.
- Character fetch:
  - `char_xy` is registered and updated one cycle before SETUP of the corresponding data write.
  - `lcd_data` = {1'b0, `char_code`} is captured on entry to SETUP.
  - `char_xy` holds its last value (0x1F) in IDLE.
- Timer width is sized by `$clog2` of the largest wait parameter; counters saturate, never wrap.
- `refresh` while `busy`:
  - Sets the pending flag (multiple pulses collapse into one).
  - In DONE, if pending: clear the flag and go directly to ADDR0 (`frame_done` still pulses).
- `refresh` during PWR_WAIT/INIT is absorbed by the implicit first frame, so the pending flag is cleared on entry to ADDR0 from INIT.
- `refresh` coincident with the DONE cycle counts as pending.

Optional Feature:
- Macro: LCD_AUTO_REFRESH_EN.
- Defined: DONE always returns to ADDR0; the display redraws continuously; `busy` stays 1 after reset; `refresh` is ignored; `frame_done` pulses every frame.
- Undefined: redraw only on `refresh` as described above.

Test Plan:
- Params POWERUP_CYC=20, E_PULSE_CYC=2, SETUP_CYC=1, CMD_WAIT_CYC=4, CLEAR_WAIT_CYC=10; release `rst_n`, hold `refresh`=0:
  - no `lcd_e` edge for 20 cycles;
  - then 4 command bytes 0x38, 0x0C, 0x01, 0x06 with `lcd_rs`=0;
  - gap after 0x01 ≥ 10 cycles.
- Continue with a ROM model (difficulty=0) → command 0x80, data "   DIFFICULTY:  " (0x20,0x20,0x20,0x44,…,0x3A,0x20,0x20), command 0xC0, data with 0x45,0x41,0x53,0x59 at columns 6–9; `frame_done` pulses once; `busy`=0.
- Switch ROM difficulty=1, pulse `refresh` in IDLE → row1 cols 6–9 = 0x48,0x41,0x52,0x44; exactly 34 `lcd_e` pulses.
- Pulse `refresh` 3 times during a redraw → exactly one additional frame follows with no IDLE gap, then `busy`=0.
- Assert `rst_n`=0 while `lcd_e`=1 mid-ROW0 → `lcd_e` drops immediately; after release, the full init sequence repeats starting with 0x38.
- With LCD_AUTO_REFRESH_EN defined → `frame_done` pulses periodically with no `refresh`, and `busy` never deasserts.

Source files
------------

// File: rtl/lcd_16x2_text_driver.sv
// HD44780 16x2 text driver: power-up init, then scans char_xy over 32 cells and writes each char_code byte.
// Latency: POWERUP_CYC then 4 init bytes; each byte = 1 issue + SETUP_CYC + E_PULSE_CYC + hold cycles.
// Backpressure: refresh while busy is held pending; `define LCD_AUTO_REFRESH_EN redraws continuously.
module lcd_16x2_text_driver #(
   parameter int POWERUP_CYC    = 2_000_000,
   parameter int E_PULSE_CYC    = 50,
   parameter int SETUP_CYC      = 10,
   parameter int CMD_WAIT_CYC   = 5_000,
   parameter int CLEAR_WAIT_CYC = 200_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       refresh,
   output logic [7:0] char_xy,
   input  logic [6:0] char_code,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       busy,
   output logic       frame_done
);

   localparam int MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
   localparam int MAX_B   = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
   localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef logic [TW-1:0] tmr_t;

   localparam tmr_t PWR_LAST   = tmr_t'(POWERUP_CYC - 1);
   localparam tmr_t SETUP_LAST = tmr_t'(SETUP_CYC - 1);
   localparam tmr_t PULSE_LAST = tmr_t'(E_PULSE_CYC - 1);
   localparam tmr_t CMD_LAST   = tmr_t'(CMD_WAIT_CYC - 1);
   localparam tmr_t CLR_LAST   = tmr_t'(CLEAR_WAIT_CYC - 1);

   typedef enum logic [2:0] {
      S_PWR_WAIT, S_INIT, S_ADDR0, S_ROW0, S_ADDR1, S_ROW1, S_DONE, S_IDLE
   } state_t;

   typedef enum logic [1:0] {
      W_IDLE, W_SETUP, W_PULSE, W_HOLD
   } wstate_t;

   state_t     state, state_nxt;
   wstate_t    wstate, wstate_nxt;
   tmr_t       timer, timer_nxt, timer_inc, hold_last;
   logic [1:0] init_idx, init_idx_nxt;
   logic       pending, pending_nxt;
   logic [7:0] char_xy_nxt, lcd_data_nxt, byte_val;
   logic       lcd_rs_nxt, lcd_e_nxt, busy_nxt, frame_done_nxt;
   logic       byte_rs, byte_done;

   assign lcd_rw = 1'b0;

`ifdef LCD_AUTO_REFRESH_EN
   logic unused_refresh;
   assign unused_refresh = refresh | pending;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_PWR_WAIT;
         wstate     <= W_IDLE;
         timer      <= '0;
         init_idx   <= 2'd0;
         pending    <= 1'b0;
         char_xy    <= 8'h00;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
         lcd_e      <= 1'b0;
         busy       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         wstate     <= wstate_nxt;
         timer      <= timer_nxt;
         init_idx   <= init_idx_nxt;
         pending    <= pending_nxt;
         char_xy    <= char_xy_nxt;
         lcd_rs     <= lcd_rs_nxt;
         lcd_data   <= lcd_data_nxt;
         lcd_e      <= lcd_e_nxt;
         busy       <= busy_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wstate_nxt   = wstate;
      timer_nxt    = timer;
      init_idx_nxt = init_idx;
      pending_nxt  = pending;
      char_xy_nxt  = char_xy;
      lcd_rs_nxt   = lcd_rs;
      lcd_data_nxt = lcd_data;
      byte_done    = 1'b0;
      byte_rs      = 1'b0;
      byte_val     = 8'h00;
      timer_inc    = (timer == '1) ? timer : timer + tmr_t'(1);
      hold_last    = (!lcd_rs && lcd_data == 8'h01) ? CLR_LAST : CMD_LAST;

      case (state)
         S_INIT: begin
            case (init_idx)
               2'd0:    byte_val = 8'h38;
               2'd1:    byte_val = 8'h0C;
               2'd2:    byte_val = 8'h01;
               default: byte_val = 8'h06;
            endcase
         end
         S_ADDR0: byte_val = 8'h80;
         S_ADDR1: byte_val = 8'hC0;
         S_ROW0, S_ROW1: begin
            byte_rs  = 1'b1;
            byte_val = {1'b0, char_code};
         end
         default: ;
      endcase

`ifndef LCD_AUTO_REFRESH_EN
      // Any request not taken directly from IDLE collapses into one pending redraw.
      if (refresh && state != S_IDLE)
         pending_nxt = 1'b1;
`endif

      case (state)
         S_PWR_WAIT: begin
            if (timer == PWR_LAST) begin
               state_nxt = S_INIT;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer_inc;
            end
         end
         S_IDLE: begin
`ifndef LCD_AUTO_REFRESH_EN
            if (refresh)
               state_nxt = S_ADDR0;
`endif
         end
         S_DONE: begin
`ifdef LCD_AUTO_REFRESH_EN
            state_nxt = S_ADDR0;
`else
            if (pending || refresh) begin
               state_nxt   = S_ADDR0;
               pending_nxt = 1'b0;
            end else begin
               state_nxt = S_IDLE;
            end
`endif
         end
         default: begin
            case (wstate)
               W_IDLE: begin
                  wstate_nxt   = W_SETUP;
                  timer_nxt    = '0;
                  lcd_rs_nxt   = byte_rs;
                  lcd_data_nxt = byte_val;
               end
               W_SETUP: begin
                  if (timer == SETUP_LAST) begin
                     wstate_nxt = W_PULSE;
                     timer_nxt  = '0;
                  end else begin
                     timer_nxt = timer_inc;
                  end
               end
               W_PULSE: begin
                  if (timer == PULSE_LAST) begin
                     wstate_nxt = W_HOLD;
                     timer_nxt  = '0;
                  end else begin
                     timer_nxt = timer_inc;
                  end
               end
               default: begin
                  if (timer == hold_last) begin
                     wstate_nxt = W_IDLE;
                     timer_nxt  = '0;
                     byte_done  = 1'b1;
                  end else begin
                     timer_nxt = timer_inc;
                  end
               end
            endcase

            // char_xy advances at the end of a byte so char_code settles during the issue cycle.
            if (byte_done) begin
               case (state)
                  S_INIT: begin
                     if (init_idx == 2'd3) begin
                        state_nxt    = S_ADDR0;
                        init_idx_nxt = 2'd0;
                        pending_nxt  = 1'b0;
                     end else begin
                        init_idx_nxt = init_idx + 2'd1;
                     end
                  end
                  S_ADDR0: begin
                     state_nxt   = S_ROW0;
                     char_xy_nxt = 8'h00;
                  end
                  S_ROW0: begin
                     if (char_xy[3:0] == 4'hF)
                        state_nxt = S_ADDR1;
                     else
                        char_xy_nxt = char_xy + 8'd1;
                  end
                  S_ADDR1: begin
                     state_nxt   = S_ROW1;
                     char_xy_nxt = 8'h10;
                  end
                  S_ROW1: begin
                     if (char_xy[3:0] == 4'hF)
                        state_nxt = S_DONE;
                     else
                        char_xy_nxt = char_xy + 8'd1;
                  end
                  default: ;
               endcase
            end
         end
      endcase

      lcd_e_nxt      = (wstate_nxt == W_PULSE);
      busy_nxt       = (state_nxt != S_IDLE);
      frame_done_nxt = (state_nxt == S_DONE);
   end

endmodule

// File: tb/tb_lcd_16x2_text_driver.sv
// Directed bench for lcd_16x2_text_driver with short timing parameters and a two-screen ROM model.
`timescale 1ns/1ps
module tb_lcd_16x2_text_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       refresh;
   logic [7:0] char_xy;
   logic [6:0] char_code;
   logic       lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_data;
   logic       busy, frame_done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lcd_16x2_text_driver #(
      .POWERUP_CYC(20), .E_PULSE_CYC(2), .SETUP_CYC(1),
      .CMD_WAIT_CYC(4), .CLEAR_WAIT_CYC(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .refresh(refresh),
      .char_xy(char_xy), .char_code(char_code),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
      .lcd_data(lcd_data), .busy(busy), .frame_done(frame_done)
   );

   // ROM model: row 0 "   DIFFICULTY:  ", row 1 "EASY"/"HARD" at columns 6..9
   logic       diff;
   logic [7:0] rom_byte;
   logic [7:0] row0_tbl [16] = '{8'h20, 8'h20, 8'h20, 8'h44, 8'h49, 8'h46, 8'h46, 8'h49,
                                 8'h43, 8'h55, 8'h4C, 8'h54, 8'h59, 8'h3A, 8'h20, 8'h20};
   logic [7:0] easy_tbl [16] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h45, 8'h41,
                                 8'h53, 8'h59, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
   logic [7:0] hard_tbl [16] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h48, 8'h41,
                                 8'h52, 8'h44, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};

   always_comb begin
      if (char_xy[7:4] == 4'h0)      rom_byte = row0_tbl[char_xy[3:0]];
      else if (char_xy[7:4] != 4'h1) rom_byte = 8'h7F;
      else if (diff)                 rom_byte = hard_tbl[char_xy[3:0]];
      else                           rom_byte = easy_tbl[char_xy[3:0]];
   end
   assign char_code = rom_byte[6:0];

   // Bus monitor: logs every byte latched on an lcd_e rise, with edge times in cycles.
   int         cyc = 0;
   logic [8:0] byte_q [$];
   int         rise_q [$];
   int         fall_q [$];
   int         fd_count = 0;
   int         busy_low = 0;
   int         data_glitch = 0;
   logic       prev_e = 1'b0;
   logic [8:0] cur_byte = 9'h000;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (lcd_e && !prev_e) begin
         byte_q.push_back({lcd_rs, lcd_data});
         rise_q.push_back(cyc);
         cur_byte = {lcd_rs, lcd_data};
      end else if (lcd_e && {lcd_rs, lcd_data} != cur_byte) begin
         data_glitch++;
      end
      if (!lcd_e && prev_e) fall_q.push_back(cyc);
      if (frame_done) fd_count++;
      if (!busy) busy_low++;
      prev_e = lcd_e;
   end

   function automatic logic [8:0] qbyte(input int i);
      if (i < byte_q.size()) return byte_q[i];
      return 9'h1FF;
   endfunction

   function automatic int qrise(input int i);
      if (i < rise_q.size()) return rise_q[i];
      return -100000;
   endfunction

   function automatic int qfall(input int i);
      if (i < fall_q.size()) return fall_q[i];
      return 100000;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
   endtask

   task automatic clear_log();
      byte_q.delete();
      rise_q.delete();
      fall_q.delete();
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int k = 0;
      while (byte_q.size() < n && k < budget) begin
         tick();
         k++;
      end
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (fd_count < n && k < budget) begin
         tick();
         k++;
      end
   endtask

   int rel_cyc;

   task automatic test_reset();
      rst_n = 1'b0; refresh = 1'b0; diff = 1'b0;
      repeat (3) tick();
      clear_log();
      checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL reset_e: got %b expected 0", lcd_e); end
      checks++; if (lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
      checks++; if (lcd_rw !== 1'b0) begin failures++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
      checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", lcd_data); end
      checks++; if (char_xy !== 8'h00) begin failures++; $display("FAIL reset_xy: got %h expected 00", char_xy); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b expected 1", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
      rst_n = 1'b1;
      rel_cyc = cyc;
   endtask

   task automatic test_init(input string tag);
      logic [8:0] exp_cmd [4];
      exp_cmd = '{9'h038, 9'h00C, 9'h001, 9'h006};
      wait_bytes(4, 300);
      checks++;
      if (byte_q.size() < 4) begin failures++; $display("FAIL %s_timeout: got %0d bytes expected 4", tag, byte_q.size()); end
      checks++;
      if (qrise(0) - rel_cyc <= 20) begin failures++; $display("FAIL %s_powerup: first e rise after %0d cycles, required > 20", tag, qrise(0) - rel_cyc); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (qbyte(i) !== exp_cmd[i]) begin failures++; $display("FAIL %s_cmd%0d: got rs/data %h expected %h", tag, i, qbyte(i), exp_cmd[i]); end
      end
      checks++;
      if (qfall(0) - qrise(0) != 2) begin failures++; $display("FAIL %s_e_width: got %0d cycles expected 2", tag, qfall(0) - qrise(0)); end
      checks++;
      if (qrise(1) - qfall(0) < 4) begin failures++; $display("FAIL %s_cmd_gap: got %0d cycles required >= 4", tag, qrise(1) - qfall(0)); end
      checks++;
      if (qrise(3) - qfall(2) < 10) begin failures++; $display("FAIL %s_clear_gap: got %0d cycles required >= 10", tag, qrise(3) - qfall(2)); end
   endtask

   task automatic test_first_frame();
      logic [8:0] exp;
      wait_frames(1, 1000);
      checks++;
      if (fd_count < 1) begin failures++; $display("FAIL frame1_timeout: got %0d frame_done expected 1", fd_count); end
      checks++;
      if (byte_q.size() != 38) begin failures++; $display("FAIL frame1_bytes: got %0d expected 38", byte_q.size()); end
      checks++;
      if (qbyte(4) !== 9'h080) begin failures++; $display("FAIL frame1_addr0: got %h expected 080", qbyte(4)); end
      checks++;
      if (qbyte(21) !== 9'h0C0) begin failures++; $display("FAIL frame1_addr1: got %h expected 0C0", qbyte(21)); end
      for (int c = 0; c < 16; c++) begin
         exp = {1'b1, row0_tbl[c]};
         checks++;
         if (qbyte(5 + c) !== exp) begin failures++; $display("FAIL frame1_row0_col%0d: got %h expected %h", c, qbyte(5 + c), exp); end
         exp = {1'b1, easy_tbl[c]};
         checks++;
         if (qbyte(22 + c) !== exp) begin failures++; $display("FAIL frame1_row1_col%0d: got %h expected %h", c, qbyte(22 + c), exp); end
      end
      repeat (2) tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame1_idle_busy: got %b expected 0", busy); end
      checks++; if (fd_count != 1) begin failures++; $display("FAIL frame1_fd_count: got %0d expected 1", fd_count); end
      checks++; if (char_xy !== 8'h1F) begin failures++; $display("FAIL frame1_idle_xy: got %h expected 1F", char_xy); end
      checks++; if (data_glitch != 0) begin failures++; $display("FAIL frame1_bus_stable: got %0d changes expected 0", data_glitch); end
   endtask

   task automatic test_refresh_idle();
      int fd0;
      diff = 1'b1;
      clear_log();
      fd0 = fd_count;
      pulse_refresh();
      wait_frames(fd0 + 1, 1000);
      repeat (3) tick();
      checks++; if (fd_count != fd0 + 1) begin failures++; $display("FAIL redraw_fd: got %0d expected %0d", fd_count, fd0 + 1); end
      checks++; if (byte_q.size() != 34) begin failures++; $display("FAIL redraw_pulses: got %0d expected 34", byte_q.size()); end
      checks++; if (qbyte(0) !== 9'h080) begin failures++; $display("FAIL redraw_addr0: got %h expected 080", qbyte(0)); end
      checks++; if (qbyte(17) !== 9'h0C0) begin failures++; $display("FAIL redraw_addr1: got %h expected 0C0", qbyte(17)); end
      for (int c = 6; c < 10; c++) begin
         checks++;
         if (qbyte(18 + c) !== {1'b1, hard_tbl[c]}) begin failures++; $display("FAIL redraw_row1_col%0d: got %h expected %h", c, qbyte(18 + c), {1'b1, hard_tbl[c]}); end
      end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL redraw_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int fd0;
      clear_log();
      fd0 = fd_count;
      busy_low = 0;
      pulse_refresh();
      repeat (30) tick();
      pulse_refresh();
      repeat (80) tick();
      pulse_refresh();
      repeat (80) tick();
      pulse_refresh();
      wait_frames(fd0 + 2, 1500);
      checks++; if (fd_count != fd0 + 2) begin failures++; $display("FAIL b2b_frames: got %0d expected %0d", fd_count, fd0 + 2); end
      checks++; if (busy_low != 0) begin failures++; $display("FAIL b2b_gap: busy low for %0d cycles expected 0", busy_low); end
      repeat (400) tick();
      checks++; if (fd_count != fd0 + 2) begin failures++; $display("FAIL b2b_extra: got %0d frames expected %0d", fd_count, fd0 + 2); end
      checks++; if (byte_q.size() != 68) begin failures++; $display("FAIL b2b_pulses: got %0d expected 68", byte_q.size()); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b expected 0", busy); end
   endtask

   task automatic test_refresh_at_done();
      int fd0;
      int k;
      fd0 = fd_count;
      pulse_refresh();
      k = 0;
      while (frame_done !== 1'b1 && k < 1000) begin
         tick();
         k++;
      end
      refresh = 1'b1;
      tick();
      refresh = 1'b0;
      wait_frames(fd0 + 2, 1000);
      checks++; if (fd_count != fd0 + 2) begin failures++; $display("FAIL done_refresh_frames: got %0d expected %0d", fd_count, fd0 + 2); end
      repeat (400) tick();
      checks++; if (fd_count != fd0 + 2) begin failures++; $display("FAIL done_refresh_extra: got %0d expected %0d", fd_count, fd0 + 2); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_refresh_busy: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid();
      int k;
      int fd0;
      clear_log();
      pulse_refresh();
      k = 0;
      while (!(lcd_e === 1'b1 && lcd_rs === 1'b1 && byte_q.size() >= 4) && k < 500) begin
         tick();
         k++;
      end
      checks++; if (lcd_e !== 1'b1) begin failures++; $display("FAIL midrst_setup: lcd_e got %b expected 1", lcd_e); end
      rst_n = 1'b0;
      #1;
      checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL midrst_e: got %b expected 0", lcd_e); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy: got %b expected 1", busy); end
      checks++; if (lcd_data !== 8'h00) begin failures++; $display("FAIL midrst_data: got %h expected 00", lcd_data); end
      repeat (2) tick();
      clear_log();
      fd0 = fd_count;
      rst_n = 1'b1;
      rel_cyc = cyc;
      test_init("reinit");
      wait_frames(fd0 + 1, 1000);
      repeat (2) tick();
      checks++; if (fd_count != fd0 + 1) begin failures++; $display("FAIL reinit_frame: got %0d expected %0d", fd_count, fd0 + 1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reinit_busy: got %b expected 0", busy); end
   endtask

   task automatic test_auto();
      busy_low = 0;
      wait_frames(3, 2000);
      checks++; if (fd_count < 3) begin failures++; $display("FAIL auto_frames: got %0d expected >= 3", fd_count); end
      checks++; if (busy_low != 0) begin failures++; $display("FAIL auto_busy: busy low for %0d cycles expected 0", busy_low); end
   endtask

   initial begin
      test_reset();
      test_init("init");
`ifdef LCD_AUTO_REFRESH_EN
      test_auto();
`else
      test_first_frame();
      test_refresh_idle();
      test_back_to_back();
      test_refresh_at_done();
      test_reset_mid();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
